// File: rtl/beat_stream_if.sv
// beat_stream_if: bundles the beatmap stream, beat request and debug status
// signals of beat_stream_reader.
//   master : stream source / game logic side (drives data_en, data, beat_tick, clear_flags)
//   slave  : beat_stream_reader side (drives notes, wrap tracking, occupancy, flags)
//
// Handshake: data_en is a valid-only strobe with no ready; each cycle it is
// high, exactly one word is offered and is either stored or dropped (dropped
// words raise overflow). beat_tick is a one-cycle request answered one cycle
// later by note_valid, or by underflow when nothing is buffered.
interface beat_stream_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              data_en;
    logic [DATA_W-1:0] data;
    logic              beat_tick;
    logic              clear_flags;
    logic              note_valid;
    logic [DATA_W-1:0] note_value;
    logic [1:0]        note_lane;
    logic              wrap_pulse;
    logic [7:0]        pattern_count;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_en, data, beat_tick, clear_flags,
        input  note_valid, note_value, note_lane, wrap_pulse, pattern_count,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  data_en, data, beat_tick, clear_flags,
        output note_valid, note_value, note_lane, wrap_pulse, pattern_count,
               fifo_count, overflow, underflow
    );
endinterface

// File: rtl/beat_stream_reader.sv
// beat_stream_reader: consumer end of the beatmap data stream.
// Buffers incoming note words in a DEPTH-entry FIFO and releases one note per
// beat_tick, decoded into value and lane (value[3:2]). Counts pattern restarts
// (a word smaller than the previous one) and keeps sticky overflow/underflow
// flags for debug LEDs.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; discards buffered words
//   bus   : beat_stream_if slave modport (stream in, notes/status out)
// All outputs are registers.
module beat_stream_reader #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    beat_stream_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] last_word;
    logic              have_last;

    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic ovf_event;
    logic unf_event;
    logic wrap_event;

    always_comb begin
        fifo_full  = (count == CNT_FULL);
        fifo_empty = (count == '0);
        do_pop     = bus.beat_tick && !fifo_empty;
        // A full FIFO still accepts a word when a pop frees the head slot in
        // the same cycle. An empty FIFO never bypasses: the word is stored.
        do_push    = bus.data_en && (!fifo_full || do_pop);
        ovf_event  = bus.data_en && fifo_full && !do_pop;
        unf_event  = bus.beat_tick && fifo_empty;
        // Wrap is judged on every offered word, stored or dropped.
        wrap_event = bus.data_en && have_last && (bus.data < last_word);
    end

    // Storage has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            last_word         <= '0;
            have_last         <= 1'b0;
            bus.note_valid    <= 1'b0;
            bus.note_value    <= '0;
            bus.note_lane     <= 2'b00;
            bus.wrap_pulse    <= 1'b0;
            bus.pattern_count <= 8'd0;
            bus.overflow      <= 1'b0;
            bus.underflow     <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            bus.note_valid <= do_pop;
            if (do_pop) begin
                rd_ptr         <= rd_ptr + PTR_ONE;
                bus.note_value <= mem[rd_ptr];
                bus.note_lane  <= mem[rd_ptr][3:2];
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            bus.wrap_pulse <= wrap_event;
            if (wrap_event && (bus.pattern_count != 8'hFF)) begin
                bus.pattern_count <= bus.pattern_count + 8'd1;
            end
            if (bus.data_en) begin
                last_word <= bus.data;
                have_last <= 1'b1;
            end

            // A new event in the clearing cycle keeps the flag set.
            if (bus.clear_flags) begin
                bus.overflow  <= ovf_event;
                bus.underflow <= unf_event;
            end else begin
                bus.overflow  <= bus.overflow  | ovf_event;
                bus.underflow <= bus.underflow | unf_event;
            end
        end
    end

    assign bus.fifo_count = count;
endmodule

// File: tb/tb_beat_stream_reader.sv
// tb_beat_stream_reader: directed and randomized checks of beat_stream_reader
// against a queue-based reference model of the stream/beat rules.
module tb_beat_stream_reader;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    beat_stream_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus_if ();

    beat_stream_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              m_valid;
    logic [DATA_W-1:0] m_value;
    logic              m_wrap;
    int                m_pc;
    logic              m_ovf;
    logic              m_unf;
    logic [DATA_W-1:0] m_last;
    logic              m_have;

    task automatic model_reset();
        exp_q.delete();
        m_valid = 1'b0;
        m_value = '0;
        m_wrap  = 1'b0;
        m_pc    = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = '0;
        m_have  = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [DATA_W-1:0] d,
                              input logic tick, input logic clr);
        int  size0;
        logic pop, push, ovf_ev, unf_ev;
        size0  = exp_q.size();
        pop    = tick && (size0 > 0);
        push   = en && ((size0 < DEPTH) || pop);
        ovf_ev = en && (size0 == DEPTH) && !pop;
        unf_ev = tick && (size0 == 0);
        m_valid = pop;
        if (pop) m_value = exp_q.pop_front();
        if (push) exp_q.push_back(d);
        m_ovf = clr ? ovf_ev : (m_ovf || ovf_ev);
        m_unf = clr ? unf_ev : (m_unf || unf_ev);
        m_wrap = en && m_have && (d < m_last);
        if (m_wrap && m_pc < 255) m_pc++;
        if (en) begin
            m_last = d;
            m_have = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".note_valid"},    32'(bus_if.note_valid),    32'(m_valid));
        check({tag, ".note_value"},    32'(bus_if.note_value),    32'(m_value));
        check({tag, ".note_lane"},     32'(bus_if.note_lane),     32'(m_value[3:2]));
        check({tag, ".fifo_count"},    32'(bus_if.fifo_count),    32'(exp_q.size()));
        check({tag, ".wrap_pulse"},    32'(bus_if.wrap_pulse),    32'(m_wrap));
        check({tag, ".pattern_count"}, 32'(bus_if.pattern_count), 32'(m_pc));
        check({tag, ".overflow"},      32'(bus_if.overflow),      32'(m_ovf));
        check({tag, ".underflow"},     32'(bus_if.underflow),     32'(m_unf));
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic en, input logic [DATA_W-1:0] d,
                        input logic tick, input logic clr, input string tag);
        @(negedge clk);
        bus_if.data_en     = en;
        bus_if.data        = d;
        bus_if.beat_tick   = tick;
        bus_if.clear_flags = clr;
        @(posedge clk);
        model_step(en, d, tick, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset              = 1'b1;
        bus_if.data_en     = 1'b1;
        bus_if.data        = 8'(($urandom_range(0, 255)));
        bus_if.beat_tick   = 1'b1;
        bus_if.clear_flags = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset            = 1'b0;
        bus_if.data_en   = 1'b0;
        bus_if.beat_tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] pat [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.data_en     = 1'b0;
        bus_if.data        = '0;
        bus_if.beat_tick   = 1'b0;
        bus_if.clear_flags = 1'b0;
        model_reset();
        pat[0] = 8'd180; pat[1] = 8'd184; pat[2] = 8'd188; pat[3] = 8'd192; pat[4] = 8'd196;
        repeat (2) @(posedge clk);

        // Reset with data_en and beat_tick active.
        do_reset("reset");
        check("reset.fifo_count_zero", 32'(bus_if.fifo_count), 32'd0);

        // Ordered fill then drain.
        for (int i = 0; i < 5; i++) step(1'b1, pat[i], 1'b0, 1'b0, "fill");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, "drain");
            check("drain.value_direct", 32'(bus_if.note_value), 32'(pat[i]));
        end
        check("drain.lane_last", 32'(bus_if.note_lane), 32'd1);
        check("drain.empty", 32'(bus_if.fifo_count), 32'd0);

        // Overflow: 10 words into an 8-deep FIFO.
        do_reset("reset2");
        for (int i = 0; i < 10; i++) step(1'b1, pat[i % 5], 1'b0, 1'b0, "ovf_fill");
        check("ovf.count_full", 32'(bus_if.fifo_count), 32'd8);
        check("ovf.flag_set", 32'(bus_if.overflow), 32'd1);
        step(1'b0, 8'd0, 1'b0, 1'b1, "ovf_clear");
        check("ovf.flag_cleared", 32'(bus_if.overflow), 32'd0);

        // Full simultaneous push+pop.
        step(1'b1, 8'd77, 1'b1, 1'b0, "full_pushpop");
        check("full_pushpop.head", 32'(bus_if.note_value), 32'd180);
        check("full_pushpop.count", 32'(bus_if.fifo_count), 32'd8);
        check("full_pushpop.no_ovf", 32'(bus_if.overflow), 32'd0);

        // Clear in the same cycle as a new overflow: set wins.
        step(1'b1, 8'd5, 1'b0, 1'b1, "clear_vs_set");

        // Underflow with simultaneous push on an empty FIFO.
        do_reset("reset3");
        step(1'b1, 8'd200, 1'b1, 1'b0, "unf_push");
        check("unf.flag", 32'(bus_if.underflow), 32'd1);
        check("unf.count", 32'(bus_if.fifo_count), 32'd1);
        step(1'b0, 8'd0, 1'b1, 1'b0, "unf_pop");
        check("unf.value", 32'(bus_if.note_value), 32'd200);

        // Wrap counting over 3 patterns, draining as we go.
        do_reset("reset4");
        for (int i = 0; i < 15; i++) step(1'b1, pat[i % 5], 1'b1, 1'b0, "wrap");
        check("wrap.count", 32'(bus_if.pattern_count), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd196, 1'b1, 1'b0, "wrap_equal");
        check("wrap.equal_no_pulse", 32'(bus_if.wrap_pulse), 32'd0);

        // Saturation after 300 restarts.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'd250, 1'b1, 1'b0, "sat_hi");
            step(1'b1, 8'd10,  1'b1, 1'b0, "sat_lo");
        end
        check("sat.count", 32'(bus_if.pattern_count), 32'd255);

        // Randomized traffic with occasional mid-run resets.
        do_reset("reset5");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                step(1'($urandom_range(0, 99) < 55),
                     8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 99) < 50),
                     1'($urandom_range(0, 19) == 0),
                     "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
